// File: rtl/tick_meter_pkg.sv
// Shared types and default constants for the tick_meter period monitor.
// The optional input synchronizer is enabled with the TICK_METER_SYNC_EN macro.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    localparam int          TICK_METER_CNT_W   = 32;
    localparam int unsigned TICK_METER_TIMEOUT = 500_000_000;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the measured tick, with an optional two-flop
// synchronizer in front of it when TICK_METER_SYNC_EN is defined.
module tick_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick_in,
    output logic o_rise
);

    logic w_tick;
    logic r_tick_q;
    logic r_tick_d;

`ifdef TICK_METER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_tick_in};
        end
    end

    assign w_tick = r_sync[1];
`else
    assign w_tick = i_tick_in;
`endif

    // Both samples are registered so the rise seen by the FSM never depends
    // combinationally on the input pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_q <= 1'b0;
            r_tick_d <= 1'b0;
        end else begin
            r_tick_q <= w_tick;
            r_tick_d <= r_tick_q;
        end
    end

    assign o_rise = r_tick_q & ~r_tick_d;

endmodule

// File: rtl/tick_meter.sv
// Measures clk cycles between tick rises, strobes each period, flags loss of
// the tick after TIMEOUT cycles and reports lock on two equal periods.
// Define TICK_METER_SYNC_EN to synchronize an asynchronous tick_in.
module tick_meter
    import tick_meter_pkg::*;
#(
    parameter int          CNT_W   = TICK_METER_CNT_W,
    parameter int unsigned TIMEOUT = TICK_METER_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick_in,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_timeout,
    output logic             o_locked,
    output state_t           o_state
);

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_rise;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_pv,     w_pv_nxt;
    logic             r_to,     w_to_nxt;
    logic             r_lock,   w_lock_nxt;
    logic             r_hist,   w_hist_nxt;

    tick_edge_det u_edge (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_tick_in (i_tick_in),
        .o_rise    (w_rise)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_to     <= 1'b0;
            r_lock   <= 1'b0;
            r_hist   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_pv     <= w_pv_nxt;
            r_to     <= w_to_nxt;
            r_lock   <= w_lock_nxt;
            r_hist   <= w_hist_nxt;
        end
    end

    // r_hist marks that r_period came from a real measurement since the last
    // IDLE/LOST exit, so a lock can only be claimed against valid history.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_pv_nxt     = 1'b0;
        w_to_nxt     = r_to;
        w_lock_nxt   = r_lock;
        w_hist_nxt   = r_hist;

        if (i_clr) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_period_nxt = '0;
            w_to_nxt     = 1'b0;
            w_lock_nxt   = 1'b0;
            w_hist_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_cnt_nxt   = CNT_ONE;
                        w_hist_nxt  = 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_pv_nxt     = 1'b1;
                        w_lock_nxt   = r_hist && (r_cnt == r_period);
                        w_hist_nxt   = 1'b1;
                        w_cnt_nxt    = CNT_ONE;
                    end else if (r_cnt == TO_VAL) begin
                        w_state_nxt = ST_LOST;
                        w_to_nxt    = 1'b1;
                        w_lock_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_LOST: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_cnt_nxt   = CNT_ONE;
                        w_to_nxt    = 1'b0;
                        w_hist_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_pv;
    assign o_timeout      = r_to;
    assign o_locked       = r_lock;
    assign o_state        = r_state;

endmodule

// File: tb/tb_tick_meter.sv
// Bench for tick_meter (CNT_W=8, TIMEOUT=20): a timestamp-based model of
// rises, periods and timeouts predicts every output cycle by cycle.
module tb_tick_meter;
    import tick_meter_pkg::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;
`ifdef TICK_METER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             i_tick_in;
    logic             i_clr;
    logic [CNT_W-1:0] o_period;
    logic             o_period_valid;
    logic             o_timeout;
    logic             o_locked;
    state_t           o_state;

    tick_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tick_in      (i_tick_in),
        .i_clr          (i_clr),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_timeout      (o_timeout),
        .o_locked       (o_locked),
        .o_state        (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 measuring, 2 lost. m_act is the cycle at which the
    // current measurement started; a period is the cycle distance between rises.
    int               now;
    int               m_mode;
    int               m_act;
    logic [3:0]       hist;
    logic [CNT_W-1:0] m_period;
    logic             m_pv;
    logic             m_to;
    logic             m_lock;
    logic             m_prev_ok;

    wire [CNT_W+2:0] obs = {o_period, o_period_valid, o_timeout, o_locked};

    function automatic logic [CNT_W+2:0] exp_vec();
        return {m_period, m_pv, m_to, m_lock};
    endfunction

    function automatic state_t exp_state();
        return (m_mode == 0) ? ST_IDLE : (m_mode == 1) ? ST_MEASURE : ST_LOST;
    endfunction

    task automatic model_reset();
        now = 0; m_mode = 0; m_act = 0; hist = 4'b0;
        m_period = '0; m_pv = 1'b0; m_to = 1'b0; m_lock = 1'b0; m_prev_ok = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
    task automatic step(input logic tick, input logic clr);
        logic rise;
        i_tick_in = tick;
        i_clr     = clr;
        @(posedge clk);
        now++;
        rise = hist[SYNC_LAT] && !hist[SYNC_LAT+1];
        hist = {hist[2:0], tick};
        m_pv = 1'b0;
        if (clr) begin
            m_mode = 0; m_period = '0; m_to = 1'b0; m_lock = 1'b0; m_prev_ok = 1'b0;
        end else if (rise) begin
            if (m_mode == 1) begin
                m_lock    = m_prev_ok && (CNT_W'(now - m_act) == m_period);
                m_period  = CNT_W'(now - m_act);
                m_pv      = 1'b1;
                m_prev_ok = 1'b1;
            end else begin
                m_to      = 1'b0;
                m_prev_ok = 1'b0;
            end
            m_mode = 1;
            m_act  = now;
        end else if (m_mode == 1 && (now - m_act) == TIMEOUT) begin
            m_mode = 2; m_to = 1'b1; m_lock = 1'b0;
        end
        #1;
        i_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_tick_in = 1'b0; i_clr = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", obs);
        end
        n_cmp++;
        if (o_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", o_state, ST_IDLE);
        end
    endtask

    task automatic test_periodic();
        for (int c = 0; c < 5 * 4 + 3 + SYNC_LAT; c++) begin
            step((c % 5) == 0 && c < 20, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL periodic c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (o_state !== exp_state()) begin
                n_fail++; $display("FAIL periodic_state c=%0d: got %0d want %0d", c, o_state, exp_state());
            end
        end
        // Four rises five apart: three periods of 5, the last two matching.
        n_cmp++;
        if ({o_period, o_locked, o_timeout} !== {8'd5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL periodic_final: got p=%0d l=%0d t=%0d want p=5 l=1 t=0",
                               o_period, o_locked, o_timeout);
        end
    endtask

    task automatic test_period_change();
        step(1'b0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step((c % 5) == 0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL change5 c=%0d: got %h want %h", c, obs, exp_vec());
            end
        end
        for (int c = 0; c < 24; c++) begin
            step((c % 7) == 0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL change7 c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (o_state !== exp_state()) begin
                n_fail++; $display("FAIL change7_state c=%0d: got %0d want %0d", c, o_state, exp_state());
            end
        end
    endtask

    task automatic test_timeout();
        logic tk;
        step(1'b0, 1'b1);
        for (int c = 0; c < 42 + SYNC_LAT; c++) begin
            tk = (c == 0) || (c == 31) || (c == 37);
            step(tk, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL timeout c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (o_state !== exp_state()) begin
                n_fail++; $display("FAIL timeout_state c=%0d: got %0d want %0d", c, o_state, exp_state());
            end
        end
        n_cmp++;
        if ({o_period, o_timeout} !== {8'd6, 1'b0}) begin
            n_fail++; $display("FAIL timeout_final: got p=%0d t=%0d want p=6 t=0", o_period, o_timeout);
        end
    endtask

    task automatic test_boundary();
        logic tk;
        step(1'b0, 1'b1);
        for (int c = 0; c < 90; c++) begin
            tk = (c == 0) || (c == 20) || (c == 40) || (c == 61) || (c == 81);
            step(tk, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL boundary c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (o_state !== exp_state()) begin
                n_fail++; $display("FAIL boundary_state c=%0d: got %0d want %0d", c, o_state, exp_state());
            end
        end
    endtask

    task automatic test_clr();
        for (int c = 0; c < 30; c++) begin
            step((c % 5) == 0, c == 11 + SYNC_LAT);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL clr c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (o_state !== exp_state()) begin
                n_fail++; $display("FAIL clr_state c=%0d: got %0d want %0d", c, o_state, exp_state());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1);
        for (int c = 0; c < 13; c++) step((c % 5) == 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        if (o_state !== ST_IDLE) begin
            n_fail++; $display("FAIL async_reset_state: got %0d want %0d", o_state, ST_IDLE);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5 * 4 + 3 + SYNC_LAT; c++) begin
            step((c % 5) == 0 && c < 20, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL post_reset c=%0d: got %h want %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int p;
        int w;
        logic cl;
        step(1'b0, 1'b1);
        for (int r = 0; r < 40; r++) begin
            p = $urandom_range(2, 24);
            w = $urandom_range(1, p - 1);
            if ($urandom_range(0, 3) == 0) p = (r % 2) ? 7 : p;
            for (int c = 0; c < p; c++) begin
                cl = ($urandom_range(0, 63) == 0);
                step(c < w, cl);
                n_cmp++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random r=%0d c=%0d: got %h want %h", r, c, obs, exp_vec());
                end
                n_cmp++;
                if (o_state !== exp_state()) begin
                    n_fail++; $display("FAIL random_state r=%0d: got %0d want %0d", r, o_state, exp_state());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic prev_pv;
        step(1'b0, 1'b1);
        prev_pv = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step((c % 2) == 0, 1'b0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL b2b c=%0d: got %h want %h", c, obs, exp_vec());
            end
            n_cmp++;
            if (prev_pv && o_period_valid) begin
                n_fail++; $display("FAIL b2b_strobe c=%0d: got two consecutive strobes want single", c);
            end
            prev_pv = o_period_valid;
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_period_change();
        test_timeout();
        test_boundary();
        test_clr();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_meter.md
# tick_meter

Measures the period, in `clk` cycles, between successive rising edges of a tick or slow-clock input, such as a divider's 1 s or 10 s pulse train. It reports each completed period with a one-cycle valid strobe and flags loss of the tick after a programmable timeout. It also asserts a lock flag once the tick rate is stable. It sits downstream of the team's tick dividers as an on-chip monitor and self-check.

## Interface
- `CNT_W`, default 32: width of the period counter and the `period` output.
- `TIMEOUT`, default 500_000_000: cycles without a rising edge before the tick is declared lost (10 s at 50 MHz). Requires 2 ≤ `TIMEOUT` < 2^`CNT_W`.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `tick_in`, input, 1: measured signal (pulse train or slow clock).
- `clr`, input, 1: synchronous clear. Returns the block to IDLE.
- `period`, output, `CNT_W`: last measured period in `clk` cycles. Held between updates.
- `period_valid`, output, 1: one-cycle strobe on each `period` update.
- `timeout`, output, 1: level. High while in LOST.
- `locked`, output, 1: level. High while the last two measured periods are equal.

## Operation
- Rise detect: `rise` = `tick_in` & ~`tick_d`, where `tick_d` is `tick_in` registered. The minimum measurable period is 2.
- States:
  - IDLE: waiting for the first rise.
  - MEASURE: counting cycles since the last rise.
  - LOST: timed out, waiting for a rise.
- IDLE on `rise` → MEASURE, `cnt` ← 1. No `period_valid`, because no period is known yet.
- MEASURE on `rise` → `period` ← `cnt`, `period_valid` ← 1, `cnt` ← 1.
  - `locked` ← 1 if the new `cnt` equals the previous `period` and the previous value came from a valid measurement. Otherwise `locked` ← 0.
- MEASURE with no `rise` and `cnt` == `TIMEOUT` → LOST. `timeout` ← 1, `locked` ← 0, `period` held.
- MEASURE with no `rise` and `cnt` < `TIMEOUT` → `cnt` ← `cnt`+1.
- LOST on `rise` → MEASURE, `cnt` ← 1, `timeout` ← 0. No `period_valid`. The next completed period is the first valid one, and the lock history is discarded.
- `cnt` never exceeds `TIMEOUT`, so it cannot wrap.
- A `rise` in the same cycle that `cnt` == `TIMEOUT`: the rise wins. `period` ← `TIMEOUT` with `period_valid`, and the block stays in MEASURE.
- `clr` has priority over `rise`. It sets state IDLE and `cnt`, `period`, `period_valid`, `timeout`, `locked` ← 0. `tick_d` keeps sampling, so an edge straddling `clr` is not double-detected.
- Reset while measuring: all state is lost immediately, with the same values as `clr`.

## Timing
- Reset values: `period`=0, `period_valid`=0, `timeout`=0, `locked`=0, state IDLE, `cnt`=0, `tick_d`=0.
- If `tick_in` is first sampled high at posedge N after being low at N−1, `period`, `period_valid` and `locked` update at posedge N+1. That is one cycle of latency from the sampled edge, without the synchronizer.
- `period_valid` is high for exactly one cycle per completed period. It is never high on two consecutive cycles.
- `timeout` rises at the posedge after the cycle where `cnt` == `TIMEOUT` with no rise. For a tick that stops, this is `TIMEOUT`+1 cycles after the last detected rise.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `TICK_METER_SYNC_EN` defined: a two-flop synchronizer is placed ahead of the rise detector, so `tick_in` may be asynchronous to `clk`. All output events shift 2 cycles later. Measured period values are unchanged.
- `TICK_METER_SYNC_EN` undefined: `tick_in` must be synchronous to `clk`. It feeds `tick_d` directly.

## Structure
- Shared package `tick_meter_pkg` holds:
  - the state enum `ST_IDLE`, `ST_MEASURE`, `ST_LOST` (2-bit encoding);
  - default constants `TICK_METER_CNT_W` = 32 and `TICK_METER_TIMEOUT` = 500_000_000.
- One sub-module, `tick_edge_det`, contains the optional synchronizer, the `tick_d` register and the `rise` output. Its reset is the same as the parent's.
- The FSM, counter and lock compare live in `tick_meter`.

## Test plan
All scenarios use `CNT_W`=8 and `TIMEOUT`=20.
- Periodic tick, high 1 cycle every 5 cycles, 4 rises → first `period_valid` at the second rise +1, with `period`=5. `locked`=1 from the third rise +1. `timeout`=0 throughout.
- Tick period changes from 5 to 7 → `period`=7 with `locked`=0 on the first changed measurement, then `locked`=1 on the next.
- One rise, then hold `tick_in` low → `timeout`=1 exactly 21 cycles after the rise. `period` is held and `locked`=0. The next rise clears `timeout` with no `period_valid`, and the following rise 6 cycles later gives `period`=6.
- Rise exactly 20 cycles after the previous rise → `period`=20, `period_valid`=1, `timeout` stays 0.
- `clr` asserted in the same cycle as a rise, mid-measurement → all outputs 0 and state IDLE. The next two rises 5 apart give `period`=5 only at the second.
- `rst_n` pulsed low asynchronously, mid-cycle, during MEASURE → outputs 0 immediately. With `TICK_METER_SYNC_EN` defined, the periodic scenario repeats with all events 2 cycles later.
